mem_port_arbiter: RTL and testbench

- Shares the single-port data memory between the pipeline memory stage (load/store/push/pop, framebuffer load/store) and the framebuffer scan-out burst reader.
- Owns the memory address, data and control pins.
- Grants one requester per cycle; the pipeline has priority, bounded by a starvation limit for the framebuffer.
- Raises a stall to the pipeline whenever its access is not granted this cycle.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_burst_addr_gen.sv | 34 +++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, FSM state and read-tag encodings for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 16;
    localparam int BURST_LEN_D = 8;
    localparam int MAX_WAIT_D  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        BURST   = 2'd2
    } state_t;

    typedef enum logic {
        TAG_CPU = 1'b0,
        TAG_FB  = 1'b1
    } tag_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline, framebuffer and memory pin bundle; slave is the arbiter side
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W
) ();
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [1:0]            cpu_byte_en;
    logic                  cpu_stall;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_rvalid;
    logic                  fb_start;
    logic [ADDR_WIDTH-1:0] fb_base;
    logic                  fb_busy;
    logic [DATA_WIDTH-1:0] fb_rdata;
    logic                  fb_rvalid;
    logic                  fb_done;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [1:0]            mem_byte_en;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en, fb_start, fb_base, mem_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid, fb_busy, fb_rdata, fb_rvalid, fb_done,
               mem_en, mem_we, mem_addr, mem_wdata, mem_byte_en
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en, fb_start, fb_base, mem_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid, fb_busy, fb_rdata, fb_rvalid, fb_done,
               mem_en, mem_we, mem_addr, mem_wdata, mem_byte_en
    );
endinterface

// File: rtl/mem_burst_addr_gen.sv
// mem_burst_addr_gen: framebuffer burst address = latched base + beat offset, wrapping at 2^ADDR_WIDTH
module mem_burst_addr_gen
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int BURST_LEN  = BURST_LEN_D
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);
    logic [ADDR_WIDTH-1:0] base_q;
    logic [7:0]            offset;

    // latch the base on burst request, advance one beat per issued read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            offset <= '0;
        end else if (load) begin
            base_q <= base;
            offset <= '0;
        end else if (step) begin
            offset <= offset + 8'd1;
        end
    end

    assign addr = base_q + ADDR_WIDTH'(offset);
    assign last = offset == 8'(BURST_LEN - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the data memory between the pipeline and the framebuffer burst reader
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int BURST_LEN  = BURST_LEN_D,
    parameter int MAX_WAIT   = MAX_WAIT_D
) (
    input logic          clock,
    input logic          reset,
    mem_port_arbiter_if.slave bus
);
    state_t                state, state_nxt;
    logic [3:0]            wait_cnt;
    logic                  cpu_grant, fb_issue, last, start;
    logic                  rd_pend, rd_last;
    tag_t                  rd_tag;
    logic [ADDR_WIDTH-1:0] fb_addr;

    assign start = state == IDLE && bus.fb_start;

    mem_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .BURST_LEN(BURST_LEN)) u_addr_gen (
        .clock(clock),
        .reset(reset),
        .load (start),
        .step (fb_issue),
        .base (bus.fb_base),
        .addr (fb_addr),
        .last (last)
    );

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and grant: CPU wins until the wait budget is spent, then the burst runs to completion
    always_comb begin
        state_nxt = state;
        cpu_grant = 1'b0;
        fb_issue  = 1'b0;
        case (state)
            IDLE: begin
                cpu_grant = bus.cpu_req;
                state_nxt = bus.fb_start ? PENDING : IDLE;
            end
            PENDING: begin
                cpu_grant = bus.cpu_req && wait_cnt < 4'(MAX_WAIT);
                fb_issue  = !cpu_grant;
                state_nxt = cpu_grant ? PENDING : (last ? IDLE : BURST);
            end
            BURST: begin
                fb_issue  = 1'b1;
                state_nxt = last ? IDLE : BURST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // count CPU grants that deferred a pending burst
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                           wait_cnt <= '0;
        else if (start)                      wait_cnt <= '0;
        else if (state == PENDING && cpu_grant) wait_cnt <= wait_cnt + 4'd1;
    end

    // remember who owns the read in flight so next cycle's mem_rdata goes to the right port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_last <= 1'b0;
            rd_tag  <= TAG_CPU;
        end else begin
            rd_pend <= fb_issue || (cpu_grant && !bus.cpu_we);
            rd_last <= fb_issue && last;
            rd_tag  <= fb_issue ? TAG_FB : TAG_CPU;
        end
    end

    assign bus.cpu_stall   = bus.cpu_req && !cpu_grant;
    assign bus.cpu_rvalid  = rd_pend && rd_tag == TAG_CPU;
    assign bus.cpu_rdata   = bus.cpu_rvalid ? bus.mem_rdata : DATA_WIDTH'(0);
    assign bus.fb_rvalid   = rd_pend && rd_tag == TAG_FB;
    assign bus.fb_rdata    = bus.fb_rvalid ? bus.mem_rdata : DATA_WIDTH'(0);
    assign bus.fb_done     = bus.fb_rvalid && rd_last;
    assign bus.fb_busy     = state != IDLE;
    assign bus.mem_en      = cpu_grant || fb_issue;
    assign bus.mem_we      = cpu_grant && bus.cpu_we;
    assign bus.mem_addr    = fb_issue ? fb_addr : (cpu_grant ? bus.cpu_addr : '0);
    assign bus.mem_wdata   = bus.mem_we ? bus.cpu_wdata : '0;
    assign bus.mem_byte_en = bus.mem_we ? bus.cpu_byte_en : 2'b00;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scenarios against a shadow memory and cycle-level expectations
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int BL = 8;
    localparam int MW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem    [65536];
    logic [15:0] shadow [65536];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.BURST_LEN(BL), .MAX_WAIT(MW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // single-port memory with one-cycle read latency, driven only by the DUT pins
    always @(posedge clock) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) begin
                if (bus.mem_byte_en[0]) mem[bus.mem_addr][7:0]  <= bus.mem_wdata[7:0];
                if (bus.mem_byte_en[1]) mem[bus.mem_addr][15:8] <= bus.mem_wdata[15:8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cpu_byte_en = '0; bus.fb_start = 0; bus.fb_base = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en} !== '0) begin errors++; $display("FAIL reset_mem got en=%b we=%b addr=%h wd=%h be=%b exp all 0", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en); end
        checks++; if ({bus.fb_busy, bus.fb_rvalid, bus.fb_done, bus.cpu_rvalid, bus.cpu_stall} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {bus.fb_busy, bus.fb_rvalid, bus.fb_done, bus.cpu_rvalid, bus.cpu_stall}); end
        @(negedge clock);
        reset = 0;
        #1;
        checks++; if ({bus.mem_en, bus.mem_addr, bus.fb_busy, bus.cpu_rvalid, bus.fb_rvalid} !== '0) begin errors++; $display("FAIL post_reset_idle got en=%b addr=%h busy=%b exp 0", bus.mem_en, bus.mem_addr, bus.fb_busy); end
    endtask

    task automatic test_cpu();
        logic [15:0] a, d, e;
        logic [1:0]  be;
        for (int n = 0; n < 6; n++) begin
            a  = n == 0 ? 16'h0010 : 16'($urandom);
            d  = n == 0 ? 16'hBEEF : 16'($urandom);
            be = n == 0 ? 2'b11 : 2'($urandom);
            @(negedge clock);
            bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_byte_en = be;
            #1;
            checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall got %b exp 0", bus.cpu_stall); end
            checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en} !== {2'b11, a, d, be}) begin errors++; $display("FAIL cpu_wr_pins got en=%b we=%b addr=%h wd=%h be=%b exp 1 1 %h %h %b", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_byte_en, a, d, be); end
            if (be[0]) shadow[a][7:0]  = d[7:0];
            if (be[1]) shadow[a][15:8] = d[15:8];
            e = shadow[a];
            @(negedge clock);
            bus.cpu_we = 0;
            #1;
            checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_wr_rvalid got %b exp 0", bus.cpu_rvalid); end
            checks++; if ({bus.cpu_stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_byte_en} !== {3'b010, a, 2'b00}) begin errors++; $display("FAIL cpu_rd_pins got stall=%b en=%b we=%b addr=%h be=%b exp 0 1 0 %h 00", bus.cpu_stall, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_byte_en, a); end
            @(negedge clock);
            idle_inputs();
            #1;
            checks++; if ({bus.cpu_rvalid, bus.cpu_rdata, bus.fb_rvalid} !== {1'b1, e, 1'b0}) begin errors++; $display("FAIL cpu_rd_data got v=%b d=%h fbv=%b exp 1 %h 0", bus.cpu_rvalid, bus.cpu_rdata, bus.fb_rvalid, e); end
        end
    endtask

    task automatic test_burst(input logic [15:0] base);
        logic [15:0] a;
        @(negedge clock);
        idle_inputs();
        bus.fb_start = 1; bus.fb_base = base;
        #1;
        checks++; if ({bus.fb_busy, bus.mem_en} !== 2'b00) begin errors++; $display("FAIL burst_start got busy=%b en=%b exp 0 0", bus.fb_busy, bus.mem_en); end
        for (int i = 0; i < BL; i++) begin
            @(negedge clock);
            bus.fb_start = i == 3 || i == BL - 1;
            bus.fb_base  = ~base;
            a = base + 16'(i);
            #1;
            checks++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_byte_en, bus.fb_busy} !== {2'b10, a, 2'b00, 1'b1}) begin errors++; $display("FAIL burst_issue%0d got en=%b we=%b addr=%h be=%b busy=%b exp 1 0 %h 00 1", i, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_byte_en, bus.fb_busy, a); end
            checks++; if ({bus.fb_rvalid, bus.fb_done, bus.cpu_rvalid} !== {i > 0, 2'b00} || (i > 0 && bus.fb_rdata !== shadow[16'(a - 16'd1)])) begin errors++; $display("FAIL burst_ret%0d got v=%b done=%b d=%h exp v=%b done=0 d=%h", i, bus.fb_rvalid, bus.fb_done, bus.fb_rdata, i > 0, shadow[16'(a - 16'd1)]); end
        end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if ({bus.fb_busy, bus.mem_en, bus.fb_rvalid, bus.fb_done, bus.fb_rdata} !== {4'b0011, shadow[a]}) begin errors++; $display("FAIL burst_last got busy=%b en=%b v=%b done=%b d=%h exp 0 0 1 1 %h", bus.fb_busy, bus.mem_en, bus.fb_rvalid, bus.fb_done, bus.fb_rdata, shadow[a]); end
        @(negedge clock);
        #1;
        checks++; if ({bus.fb_busy, bus.mem_en, bus.fb_rvalid, bus.fb_done} !== 4'b0000) begin errors++; $display("FAIL burst_after got busy=%b en=%b v=%b done=%b exp 0000", bus.fb_busy, bus.mem_en, bus.fb_rvalid, bus.fb_done); end
    endtask

    task automatic test_wrap();
        test_burst(16'hFFFE);
        test_burst(16'hFFF8 | 16'($urandom_range(0, 7)));
    endtask

    task automatic test_starvation();
        logic [15:0] base, ca, prev_ca, a;
        logic        exp_cv, exp_stall;
        base = 16'($urandom);
        prev_ca = '0;
        exp_cv = 0;
        @(negedge clock);
        idle_inputs();
        for (int k = 0; k <= MW + BL + 2; k++) begin
            ca = 16'($urandom);
            bus.cpu_req = k <= MW + BL + 1; bus.cpu_addr = ca; bus.cpu_we = 0;
            bus.fb_start = k == 0; bus.fb_base = base;
            exp_stall = k > MW && k <= MW + BL;
            a = base + 16'(k - MW - 1);
            #1;
            checks++; if (bus.cpu_stall !== exp_stall) begin errors++; $display("FAIL starve_stall%0d got %b exp %b", k, bus.cpu_stall, exp_stall); end
            checks++; if (bus.mem_addr !== (exp_stall ? a : (bus.cpu_req ? ca : 16'h0))) begin errors++; $display("FAIL starve_addr%0d got %h exp %h", k, bus.mem_addr, exp_stall ? a : ca); end
            checks++; if (bus.cpu_rvalid !== exp_cv || (exp_cv && bus.cpu_rdata !== shadow[prev_ca])) begin errors++; $display("FAIL starve_cpu_ret%0d got v=%b d=%h exp v=%b d=%h", k, bus.cpu_rvalid, bus.cpu_rdata, exp_cv, shadow[prev_ca]); end
            checks++; if (bus.fb_rvalid !== (k > MW + 1 && k <= MW + BL + 1) || bus.fb_done !== (k == MW + BL + 1)) begin errors++; $display("FAIL starve_fb_ret%0d got v=%b done=%b", k, bus.fb_rvalid, bus.fb_done); end
            exp_cv = bus.cpu_req && !exp_stall;
            prev_ca = ca;
            @(negedge clock);
        end
        idle_inputs();
    endtask

    task automatic test_interleave();
        logic [15:0] base;
        base = 16'($urandom);
        @(negedge clock);
        idle_inputs();
        bus.cpu_req = 1; bus.cpu_addr = 16'h0020; bus.fb_start = 1; bus.fb_base = base;
        #1;
        checks++; if ({bus.cpu_stall, bus.mem_addr} !== {1'b0, 16'h0020}) begin errors++; $display("FAIL inter_cpu got stall=%b addr=%h exp 0 0020", bus.cpu_stall, bus.mem_addr); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if ({bus.mem_addr, bus.cpu_rvalid, bus.cpu_rdata, bus.fb_rvalid} !== {base, 1'b1, shadow[16'h0020], 1'b0}) begin errors++; $display("FAIL inter_cpu_ret got addr=%h cv=%b cd=%h fv=%b exp %h 1 %h 0", bus.mem_addr, bus.cpu_rvalid, bus.cpu_rdata, bus.fb_rvalid, base, shadow[16'h0020]); end
        @(negedge clock);
        #1;
        checks++; if ({bus.cpu_rvalid, bus.fb_rvalid, bus.fb_rdata} !== {2'b01, shadow[base]}) begin errors++; $display("FAIL inter_fb_ret got cv=%b fv=%b fd=%h exp 0 1 %h", bus.cpu_rvalid, bus.fb_rvalid, bus.fb_rdata, shadow[base]); end
        repeat (BL - 1) @(negedge clock);
        #1;
        checks++; if ({bus.fb_done, bus.fb_rdata, bus.fb_busy} !== {1'b1, shadow[16'(base + 16'(BL - 1))], 1'b0}) begin errors++; $display("FAIL inter_done got done=%b d=%h busy=%b", bus.fb_done, bus.fb_rdata, bus.fb_busy); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clock);
        idle_inputs();
        bus.fb_start = 1; bus.fb_base = 16'($urandom);
        @(negedge clock);
        bus.fb_start = 0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if ({bus.fb_busy, bus.mem_en, bus.fb_rvalid} !== 3'b111) begin errors++; $display("FAIL mid_pre got busy=%b en=%b v=%b exp 111", bus.fb_busy, bus.mem_en, bus.fb_rvalid); end
        reset = 1;
        #1;
        checks++; if ({bus.fb_busy, bus.mem_en, bus.mem_addr, bus.fb_rvalid, bus.fb_done, bus.cpu_rvalid} !== '0) begin errors++; $display("FAIL mid_reset got busy=%b en=%b addr=%h v=%b done=%b exp 0", bus.fb_busy, bus.mem_en, bus.mem_addr, bus.fb_rvalid, bus.fb_done); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i == 2) reset = 0;
            #1;
            checks++; if ({bus.fb_done, bus.fb_rvalid, bus.fb_busy} !== 3'b000) begin errors++; $display("FAIL mid_hold%0d got done=%b v=%b busy=%b exp 000", i, bus.fb_done, bus.fb_rvalid, bus.fb_busy); end
        end
        test_burst(16'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'($urandom);
            shadow[i] = mem[i];
        end
        bus.mem_rdata = '0;
        idle_inputs();
        test_reset();
        test_cpu();
        test_burst(16'h0100);
        test_burst(16'($urandom));
        test_starvation();
        test_wrap();
        test_interleave();
        test_reset_mid_burst();
        test_starvation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
